// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// Optional subtract mode (a + ~b + 1) with input port sub when DIGIT_SERIAL_ADDER_SUB_EN is defined.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0 || DIGIT == 0) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_op;
  logic             c_init;
  logic [DIGIT:0]   dsum;

  // Subtraction reuses the adder: invert B at capture and seed the carry with 1.
  always_comb begin
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    b_op   = sub ? ~b : b;
    c_init = sub ? 1'b1 : cin;
`else
    b_op   = b;
    c_init = cin;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_DIG) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    dsum    = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_op;
          carry_d = c_init;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Each new digit enters at the MSB end; after NDIG shifts digit 0 sits at the LSB.
        s_d     = WIDTH'({dsum[DIGIT-1:0], s_q} >> DIGIT);
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_DIG) cout_d = dsum[DIGIT];
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    s         = s_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4): vector table,
// hold/reset corner sequences, and a back-to-back random run against an arithmetic model.
module tb_digit_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 3 * NDIG + 10) begin
      tick;
      n++;
    end
    chk({tag, " timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic [WIDTH:0] exp);
    int n;
    a = x;
    b = y;
    cin = c;
    chk({tag, " rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    wait_valid(tag, n);
    chk({tag, " latency"}, n, NDIG);
    chk({tag, " s"}, {16'd0, s}, {16'd0, exp[WIDTH-1:0]});
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, exp[WIDTH]});
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t           tbl[7];
    logic [WIDTH:0] exp;
    logic [WIDTH:0] q[$];
    int             n, got, cyc, last;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};

    // Reset state while rst_n is held low
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst s", {16'd0, s}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].s});

    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] x, y;
      logic             c;
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      c = 1'($urandom);
      run_op($sformatf("rnd%0d", i), x, y, c, model(x, y, c, 1'b0));
    end

    // Result held in DONE while out_ready stays low; new operands ignored
    a = 16'h1111; b = 16'h2222; cin = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_valid("hold", n);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      tick;
      chk("hold valid", {31'd0, out_valid}, 32'd1);
      chk("hold s", {16'd0, s}, 32'h3333);
      chk("hold cout", {31'd0, cout}, 32'd0);
      chk("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("exit in_ready", {31'd0, in_ready}, 32'd1);
    chk("exit out_valid", {31'd0, out_valid}, 32'd0);
    chk("exit s kept", {16'd0, s}, 32'h3333);
    tick;
    chk("idle in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle s kept", {16'd0, s}, 32'h3333);

    // Reset two cycles into RUN
    a = 16'hABCD; b = 16'h1357; cin = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("midrun s", {16'd0, s}, 32'd0);
    chk("midrun cout", {31'd0, cout}, 32'd0);
    chk("midrun out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    tick;
    rst_n = 1'b1;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 17'h00002);

    // Reset while a result is waiting in DONE
    a = 16'h7777; b = 16'h8888; cin = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_valid("done_rst", n);
    #2 rst_n = 1'b0;
    #1;
    chk("donerst out_valid", {31'd0, out_valid}, 32'd0);
    chk("donerst s", {16'd0, s}, 32'd0);
    chk("donerst cout", {31'd0, cout}, 32'd0);
    tick;
    rst_n = 1'b1;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, {1'b0, 16'hFFFE});
    run_op("sub 7-5", 16'h0007, 16'h0005, 1'b1, {1'b1, 16'h0002});
    sub = 1'b0;
`endif

    // Back-to-back stream with both handshakes held high
    got = 0; cyc = 0; last = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (got < 1000 && cyc < 1000 * (NDIG + 2) + 50) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b unexpected result", 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          chk("b2b s", {16'd0, s}, {16'd0, exp[WIDTH-1:0]});
          chk("b2b cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
        end
        if (last >= 0) chk("b2b spacing", cyc - last, NDIG + 2);
        last = cyc;
        got++;
      end
      if (in_ready) begin
        q.push_back(model(a, b, cin, sub));
      end else begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
      end
      tick;
      cyc++;
    end
    chk("b2b count", got, 1000);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
